// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: MAR-addressed single-port RAM plus a memory-mapped
// bank of channel registers with write timestamps, driven by a small request FSM.
module mem_io_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RAM_AW  = 12,
    parameter int unsigned IO_BASE = 32'h0000_FE00,
    parameter int unsigned IO_CH   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MAR_LE,
    input  logic                      MAR_SEL,
    input  logic [ADDR_W-1:0]         ADDR_IN,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic                      REQ,
    input  logic                      WE,
    output logic [ADDR_W-1:0]         MAR,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      ACK,
    output logic                      BUSY,
    output logic [IO_CH*DATA_W-1:0]   IO_OUT,
    output logic [IO_CH-1:0]          IO_STB,
    output logic [DATA_W-1:0]         CYCLES
);

    localparam int unsigned RAM_DEPTH = 32'(1) << RAM_AW;
    localparam int unsigned IO_END    = IO_BASE + 2 * IO_CH;
    localparam int unsigned CH_W      = (IO_CH > 1) ? $clog2(IO_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   cycles_q, cycles_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [IO_CH-1:0]    io_stb_q, io_stb_d;
    logic [DATA_W-1:0]   io_data_q [IO_CH];
    logic [DATA_W-1:0]   io_data_d [IO_CH];
    logic [DATA_W-1:0]   io_ts_q   [IO_CH];
    logic [DATA_W-1:0]   io_ts_d   [IO_CH];

    logic [DATA_W-1:0]   ram_mem [RAM_DEPTH];
    logic [DATA_W-1:0]   ram_rd_q;
    logic [RAM_AW-1:0]   ram_addr;
    logic                ram_we;

    // Address decode of the current MAR, widened so window bounds cannot overflow
    logic [31:0]         mar_ext;
    logic [31:0]         io_off;
    logic [CH_W-1:0]     io_ch;
    logic                io_odd;
    logic                io_hit;
    logic                ram_hit;
    logic [DATA_W-1:0]   io_rd;

    assign mar_ext  = 32'(mar_q);
    assign io_hit   = (mar_ext >= IO_BASE) && (mar_ext < IO_END);
    assign ram_hit  = (mar_ext < RAM_DEPTH) && !io_hit;
    assign io_off   = mar_ext - IO_BASE;
    assign io_ch    = CH_W'(io_off >> 1);
    assign io_odd   = io_off[0];
    assign io_rd    = io_odd ? io_ts_q[io_ch] : io_data_q[io_ch];
    assign ram_addr = mar_q[RAM_AW-1:0];

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        rdata_d   = rdata_q;
        cycles_d  = cycles_q + DATA_W'(1);
        io_stb_d  = '0;
        io_data_d = io_data_q;
        io_ts_d   = io_ts_q;
        ram_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MAR_LE) begin
                    mar_d = MAR_SEL ? ADDR_W'(rdata_q) : ADDR_IN;
                end
                if (REQ) begin
                    if (WE) begin
                        state_d = S_DONE;
                        if (ram_hit) begin
                            ram_we = !RST;
                        end else if (io_hit && !io_odd) begin
                            io_data_d[io_ch] = WDATA;
                            io_ts_d[io_ch]   = cycles_q;
                            io_stb_d[io_ch]  = 1'b1;
                        end
                    end else if (ram_hit) begin
                        state_d = S_RD_WAIT;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = io_hit ? io_rd : '0;
                    end
                end
            end
            S_RD_WAIT: begin
                rdata_d = ram_rd_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d  = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            mar_q     <= '0;
            rdata_q   <= '0;
            cycles_q  <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            io_stb_q  <= '0;
            io_data_q <= '{default: '0};
            io_ts_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            rdata_q   <= rdata_d;
            cycles_q  <= cycles_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            io_stb_q  <= io_stb_d;
            io_data_q <= io_data_d;
            io_ts_q   <= io_ts_d;
        end
    end

    // Contents survive reset; the read register samples the pre-load MAR every edge
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= WDATA;
        end
        ram_rd_q <= ram_mem[ram_addr];
    end

    for (genvar k = 0; k < IO_CH; k++) begin : g_io_out
        assign IO_OUT[k*DATA_W +: DATA_W] = io_data_q[k];
    end

    assign MAR    = mar_q;
    assign RDATA  = rdata_q;
    assign ACK    = ack_q;
    assign BUSY   = busy_q;
    assign IO_STB = io_stb_q;
    assign CYCLES = cycles_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with default parameters.
module tb_mem_io_ctrl;

    logic        CLK;
    logic        RST;
    logic        MAR_LE;
    logic        MAR_SEL;
    logic [15:0] ADDR_IN;
    logic [15:0] WDATA;
    logic        REQ;
    logic        WE;
    logic [15:0] MAR;
    logic [15:0] RDATA;
    logic        ACK;
    logic        BUSY;
    logic [63:0] IO_OUT;
    logic [3:0]  IO_STB;
    logic [15:0] CYCLES;

    int total = 0;
    int bad   = 0;

    mem_io_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .MAR_LE  (MAR_LE),
        .MAR_SEL (MAR_SEL),
        .ADDR_IN (ADDR_IN),
        .WDATA   (WDATA),
        .REQ     (REQ),
        .WE      (WE),
        .MAR     (MAR),
        .RDATA   (RDATA),
        .ACK     (ACK),
        .BUSY    (BUSY),
        .IO_OUT  (IO_OUT),
        .IO_STB  (IO_STB),
        .CYCLES  (CYCLES)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] a);
        MAR_LE = 1'b1; MAR_SEL = 1'b0; ADDR_IN = a;
        tick();
        MAR_LE = 1'b0;
    endtask

    // Issue one request; report ACK latency, IO_STB right after acceptance, ACK one cycle after
    task automatic access(input logic we, input logic [15:0] wd,
                          output int lat, output logic [3:0] stb1, output logic ack_nx);
        REQ = 1'b1; WE = we; WDATA = wd;
        tick();
        REQ = 1'b0; WE = 1'b0;
        stb1 = IO_STB;
        lat  = -1;
        for (int i = 1; i <= 8; i++) begin
            if (ACK === 1'b1) begin
                lat = i;
                break;
            end
            tick();
        end
        tick();
        ack_nx = ACK;
    endtask

    task automatic test_reset();
        RST = 1'b1; MAR_LE = 1'b0; MAR_SEL = 1'b0; ADDR_IN = '0;
        WDATA = '0; REQ = 1'b0; WE = 1'b0;
        tick(); tick();
        total++; if (MAR !== 16'h0)    begin bad++; $display("FAIL rst_mar got=%h exp=0000", MAR); end
        total++; if (RDATA !== 16'h0)  begin bad++; $display("FAIL rst_rdata got=%h exp=0000", RDATA); end
        total++; if (ACK !== 1'b0)     begin bad++; $display("FAIL rst_ack got=%b exp=0", ACK); end
        total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        total++; if (IO_OUT !== 64'h0) begin bad++; $display("FAIL rst_io_out got=%h exp=0", IO_OUT); end
        total++; if (IO_STB !== 4'h0)  begin bad++; $display("FAIL rst_io_stb got=%b exp=0000", IO_STB); end
        total++; if (CYCLES !== 16'h0) begin bad++; $display("FAIL rst_cycles got=%h exp=0000", CYCLES); end
        RST = 1'b0;
        tick(); tick();
        total++; if (CYCLES !== 16'h2) begin bad++; $display("FAIL cycles_count got=%h exp=0002", CYCLES); end
    endtask

    task automatic test_ram();
        int lat; logic [3:0] stb; logic ack_nx;
        set_mar(16'h0010);
        total++; if (MAR !== 16'h0010) begin bad++; $display("FAIL ram_mar got=%h exp=0010", MAR); end
        access(1'b1, 16'hBEEF, lat, stb, ack_nx);
        total++; if (lat !== 1)        begin bad++; $display("FAIL ram_wr_lat got=%0d exp=1", lat); end
        total++; if (ack_nx !== 1'b0)  begin bad++; $display("FAIL ram_wr_ack_pulse got=%b exp=0", ack_nx); end
        total++; if (RDATA !== 16'h0)  begin bad++; $display("FAIL ram_wr_rdata got=%h exp=0000", RDATA); end
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (lat !== 2)          begin bad++; $display("FAIL ram_rd_lat got=%0d exp=2", lat); end
        total++; if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL ram_rd_data got=%h exp=beef", RDATA); end
        total++; if (ack_nx !== 1'b0)    begin bad++; $display("FAIL ram_rd_ack_pulse got=%b exp=0", ack_nx); end
    endtask

    task automatic test_io();
        int lat; logic [3:0] stb; logic ack_nx; int n;
        set_mar(16'hFE04);
        n = 0;
        while (CYCLES !== 16'h0025 && n < 200) begin tick(); n++; end
        total++; if (CYCLES !== 16'h0025) begin bad++; $display("FAIL io_cycles_align got=%h exp=0025", CYCLES); end
        access(1'b1, 16'h1234, lat, stb, ack_nx);
        total++; if (lat !== 1)          begin bad++; $display("FAIL io_wr_lat got=%0d exp=1", lat); end
        total++; if (stb !== 4'b0100)    begin bad++; $display("FAIL io_stb got=%b exp=0100", stb); end
        total++; if (IO_STB !== 4'b0000) begin bad++; $display("FAIL io_stb_pulse got=%b exp=0000", IO_STB); end
        total++; if (IO_OUT !== 64'h0000_1234_0000_0000)
                 begin bad++; $display("FAIL io_out got=%h exp=0000123400000000", IO_OUT); end
        set_mar(16'hFE05);
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (lat !== 1)          begin bad++; $display("FAIL io_ts_lat got=%0d exp=1", lat); end
        total++; if (RDATA !== 16'h0025) begin bad++; $display("FAIL io_ts_data got=%h exp=0025", RDATA); end
        set_mar(16'hFE04);
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'h1234) begin bad++; $display("FAIL io_rd_data got=%h exp=1234", RDATA); end
    endtask

    task automatic test_unmapped();
        int lat; logic [3:0] stb; logic ack_nx;
        set_mar(16'hFE05);
        access(1'b1, 16'hAAAA, lat, stb, ack_nx);
        total++; if (lat !== 1)       begin bad++; $display("FAIL ts_wr_lat got=%0d exp=1", lat); end
        total++; if (stb !== 4'b0000) begin bad++; $display("FAIL ts_wr_stb got=%b exp=0000", stb); end
        set_mar(16'h8000);
        access(1'b1, 16'hAAAA, lat, stb, ack_nx);
        total++; if (lat !== 1)       begin bad++; $display("FAIL um_wr_lat got=%0d exp=1", lat); end
        total++; if (stb !== 4'b0000) begin bad++; $display("FAIL um_wr_stb got=%b exp=0000", stb); end
        total++; if (IO_OUT !== 64'h0000_1234_0000_0000)
                 begin bad++; $display("FAIL um_io_out got=%h exp=0000123400000000", IO_OUT); end
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (lat !== 1)       begin bad++; $display("FAIL um_rd_lat got=%0d exp=1", lat); end
        total++; if (RDATA !== 16'h0) begin bad++; $display("FAIL um_rd_data got=%h exp=0000", RDATA); end
        set_mar(16'hFE05);
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'h0025) begin bad++; $display("FAIL ts_unchanged got=%h exp=0025", RDATA); end
        set_mar(16'h8010);
        access(1'b1, 16'hAAAA, lat, stb, ack_nx);
        set_mar(16'h0010);
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL um_no_alias got=%h exp=beef", RDATA); end
    endtask

    task automatic test_indirect();
        int lat; logic [3:0] stb; logic ack_nx;
        set_mar(16'h0020); access(1'b1, 16'h0030, lat, stb, ack_nx);
        set_mar(16'h0030); access(1'b1, 16'h5A5A, lat, stb, ack_nx);
        set_mar(16'h0020); access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'h0030) begin bad++; $display("FAIL ind_ptr got=%h exp=0030", RDATA); end
        MAR_LE = 1'b1; MAR_SEL = 1'b1; ADDR_IN = 16'hFFFF;
        tick();
        MAR_LE = 1'b0; MAR_SEL = 1'b0;
        total++; if (MAR !== 16'h0030) begin bad++; $display("FAIL ind_mar got=%h exp=0030", MAR); end
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (lat !== 2)          begin bad++; $display("FAIL ind_lat got=%0d exp=2", lat); end
        total++; if (RDATA !== 16'h5A5A) begin bad++; $display("FAIL ind_data got=%h exp=5a5a", RDATA); end
    endtask

    task automatic test_mar_same_edge();
        set_mar(16'h0010);
        MAR_LE = 1'b1; ADDR_IN = 16'hFE04; REQ = 1'b1; WE = 1'b0;
        tick();
        MAR_LE = 1'b0; REQ = 1'b0;
        total++; if (MAR !== 16'hFE04) begin bad++; $display("FAIL same_edge_mar got=%h exp=fe04", MAR); end
        total++; if (ACK !== 1'b0)     begin bad++; $display("FAIL same_edge_ack1 got=%b exp=0", ACK); end
        tick();
        total++; if (ACK !== 1'b1)       begin bad++; $display("FAIL same_edge_ack2 got=%b exp=1", ACK); end
        total++; if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL same_edge_data got=%h exp=beef", RDATA); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acks; int lat; logic [3:0] stb; logic ack_nx;
        set_mar(16'h0010);
        acks = 0;
        REQ = 1'b1; WE = 1'b0;
        tick();
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", BUSY); end
        if (ACK === 1'b1) acks++;
        WE = 1'b1; WDATA = 16'hDEAD;
        tick(); if (ACK === 1'b1) acks++;
        tick(); if (ACK === 1'b1) acks++;
        REQ = 1'b0; WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); if (ACK === 1'b1) acks++;
        end
        total++; if (acks !== 1)    begin bad++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", BUSY); end
        access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL b2b_no_write got=%h exp=beef", RDATA); end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        while (CYCLES !== 16'hFFFD && n < 70000) begin tick(); n++; end
        total++; if (CYCLES !== 16'hFFFD) begin bad++; $display("FAIL wrap_reach got=%h exp=fffd", CYCLES); end
        tick(); tick();
        total++; if (CYCLES !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h exp=ffff", CYCLES); end
        tick();
        total++; if (CYCLES !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", CYCLES); end
        tick();
        total++; if (CYCLES !== 16'h0001) begin bad++; $display("FAIL wrap_one got=%h exp=0001", CYCLES); end
    endtask

    task automatic test_reset_mid();
        int acks; int lat; logic [3:0] stb; logic ack_nx;
        set_mar(16'h0040); access(1'b1, 16'h1111, lat, stb, ack_nx);
        set_mar(16'h0010);
        REQ = 1'b1; WE = 1'b0;
        tick();
        REQ = 1'b0;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", BUSY); end
        RST = 1'b1;
        tick();
        total++; if (ACK !== 1'b0)     begin bad++; $display("FAIL mid_ack got=%b exp=0", ACK); end
        total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL mid_busy0 got=%b exp=0", BUSY); end
        total++; if (MAR !== 16'h0)    begin bad++; $display("FAIL mid_mar got=%h exp=0000", MAR); end
        total++; if (RDATA !== 16'h0)  begin bad++; $display("FAIL mid_rdata got=%h exp=0000", RDATA); end
        total++; if (IO_OUT !== 64'h0) begin bad++; $display("FAIL mid_io_out got=%h exp=0", IO_OUT); end
        total++; if (CYCLES !== 16'h0) begin bad++; $display("FAIL mid_cycles got=%h exp=0000", CYCLES); end
        RST = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); if (ACK === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
        // Reset must dominate a simultaneous write request and MAR load
        set_mar(16'h0040);
        RST = 1'b1; REQ = 1'b1; WE = 1'b1; WDATA = 16'h2222; MAR_LE = 1'b1; ADDR_IN = 16'h0050;
        tick();
        RST = 1'b0; REQ = 1'b0; WE = 1'b0; MAR_LE = 1'b0;
        total++; if (MAR !== 16'h0) begin bad++; $display("FAIL prio_mar got=%h exp=0000", MAR); end
        tick();
        total++; if (ACK !== 1'b0)  begin bad++; $display("FAIL prio_ack got=%b exp=0", ACK); end
        set_mar(16'h0040); access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'h1111) begin bad++; $display("FAIL prio_ram got=%h exp=1111", RDATA); end
        set_mar(16'h0010); access(1'b0, 16'h0, lat, stb, ack_nx);
        total++; if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL mid_ram_kept got=%h exp=beef", RDATA); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io();
        test_unmapped();
        test_indirect();
        test_mar_same_edge();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 16, data word width.
- ADDR_W, 16, address/MAR width.
- RAM_AW, 12, internal RAM address bits; depth 2^RAM_AW words.
- IO_BASE, 16'hFE00, base of the memory-mapped I/O window; even value.
- IO_CH, 4, number of I/O channels, 1..8.

REQ-002 Clock and reset: one clock; reset is synchronous and active-high.

REQ-003 Ports (name, direction, width, meaning):
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- MAR_LE  in  1  load MAR.
- MAR_SEL  in  1  MAR source: 1 = RDATA (indirect), 0 = ADDR_IN.
- ADDR_IN  in  ADDR_W  direct address.
- WDATA  in  DATA_W  write data.
- REQ  in  1  access request using current MAR.
- WE  in  1  write when 1, read when 0; sampled with REQ.
- MAR  out  ADDR_W  memory address register.
- RDATA  out  DATA_W  read data; valid with ACK, held until next ACK.
- ACK  out  1  one-cycle completion pulse.
- BUSY  out  1  high whenever state is not IDLE.
- IO_OUT  out  IO_CH*DATA_W  channel data registers; ch k occupies bits [k*DATA_W +: DATA_W].
- IO_STB  out  IO_CH  one-cycle pulse on a write to ch k.
- CYCLES  out  DATA_W  free-running cycle counter.

Function
REQ-004 CYCLES shall increment by 1 every cycle when RST=0 and wrap from all-ones to 0.

REQ-005 MAR shall load from the MAR_SEL-selected source on an edge where MAR_LE=1 and state is IDLE; MAR_LE shall be ignored while BUSY=1.

REQ-006 Decode of MAR for each access:
- IO hit: IO_BASE <= MAR < IO_BASE+2*IO_CH.
- Even offset 2k: data register ch k, read/write.
- Odd offset 2k+1: write timestamp of ch k, read-only.
- RAM hit: MAR < 2^RAM_AW and not an IO hit.
- Anything else is unmapped.

REQ-007 FSM states and transitions:
- IDLE: on REQ=1, go to RD_WAIT for a RAM read, otherwise go to DONE.
- RD_WAIT: one cycle for the synchronous RAM, then go to DONE.
- DONE: assert ACK for one cycle, then go to IDLE.

REQ-008 REQ shall be ignored while BUSY=1; requests shall not be queued.

REQ-009 Writes shall commit on the accepting edge (IDLE, REQ=1, WE=1):
- RAM hit: RAM word written.
- IO data hit: ch k register = WDATA, timestamp k = CYCLES value at that edge, IO_STB[k]=1 in the following cycle.
- Timestamp address or unmapped: no state change.
- ACK shall still be given in every case.

REQ-010 Latency from accepting edge to ACK high:
- Writes: 1 cycle.
- IO and unmapped reads: 1 cycle.
- RAM reads: 2 cycles.

REQ-011 RDATA shall update only on the edge entering DONE for reads:
- RAM word, channel register or timestamp, according to the decode.
- Unmapped read returns 0.
- Writes leave RDATA unchanged.

REQ-012 When MAR_LE=1 and REQ=1 on the same IDLE edge, the access shall use the MAR value before the load; MAR updates at the same edge.

REQ-013 With MAR_SEL=1, MAR shall load the RDATA value present at the loading edge (indirect addressing).

REQ-014 RAM shall be an internal single-port synchronous RAM with read latency of one edge, addressed by MAR[RAM_AW-1:0].

Reset
REQ-015 On RST=1 at an edge:
- State = IDLE.
- MAR, RDATA, CYCLES, all IO_OUT channels and all timestamps = 0.
- ACK = 0, IO_STB = 0, BUSY = 0.

REQ-016 RAM contents shall not be reset.

REQ-017 Reset shall take priority over all other inputs.

REQ-018 Reset mid-access shall abort the access:
- No ACK.
- A RAM or IO write already committed remains.

Verification
REQ-019 Bench with defaults. MAR_LE=1, MAR_SEL=0, ADDR_IN=0x0010, then REQ/WE=1, WDATA=0xBEEF -> ACK one cycle later. Then a read of 0x0010 -> ACK 2 cycles after acceptance, RDATA=0xBEEF.

REQ-020 Write 0x1234 to 0xFE04 at CYCLES=0x0025 -> IO_OUT ch2=0x1234 and IO_STB=4'b0100 for one cycle. Read 0xFE05 -> RDATA=0x0025 with 1-cycle latency.

REQ-021 Write 0xAAAA to 0xFE05 and to unmapped 0x8000 -> ACK given, no register changes. Read 0x8000 -> RDATA=0x0000.

REQ-022 Indirect: RAM[0x0020]=0x0030, RAM[0x0030]=0x5A5A. Read 0x0020, then MAR_LE with MAR_SEL=1 -> MAR=0x0030. Next read -> RDATA=0x5A5A.

REQ-023 Second REQ while BUSY=1 -> ignored, exactly one ACK. CYCLES preloaded near 0xFFFF -> wraps to 0x0000.

REQ-024 RST asserted in RD_WAIT -> no ACK, BUSY=0, all outputs 0 next cycle. A prior RAM write is still readable after reset.
